// File: rtl/tdc_test_pattern_gen.sv
// Pseudo-random ETROC2 stimulus: TDC hit words plus an L1A trigger and its look-ahead predictor.
// Define TDC_PIXELID_CAL_EN to replace the LFSR-derived CAL field with {2'b00, pixelID}.

module TestL1Generator #(
    parameter int         WORDWIDTH    = 15,
    parameter logic [8:0] FORWARDSTEPS = 9'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic dis,
    output logic L1A
);

    // Walks the all-ones seed forward so a predictor instance starts FORWARDSTEPS ahead.
    function automatic logic [WORDWIDTH-1:0] f_advance(input logic [8:0] steps);
        logic [WORDWIDTH-1:0] v;
        v = '1;
        for (int i = 0; i < 512; i++) begin
            if (i < int'(steps)) begin
                v = {v[WORDWIDTH-2:0], v[WORDWIDTH-1] ^ v[WORDWIDTH-2]};
            end
        end
        return v;
    endfunction

    localparam logic [WORDWIDTH-1:0] SEED = f_advance(FORWARDSTEPS);

    logic [WORDWIDTH-1:0] r_lfsr;

    // LFSR keeps running while disabled so the predictor stays aligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= SEED;
            L1A    <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[WORDWIDTH-2:0], r_lfsr[WORDWIDTH-1] ^ r_lfsr[WORDWIDTH-2]};
            L1A    <= (r_lfsr[4:0] == 5'd0) & ~dis;
        end
    end

endmodule

module TDCTestPatternGen (
    input  logic        clk,
    input  logic        reset,
    input  logic        dis,
    input  logic [7:0]  pixelID,
    input  logic [6:0]  occupancy,
    output logic [29:0] dout
);

    logic [30:0] r_s;
    logic [9:0]  w_cal;
    logic        w_hit;

`ifdef TDC_PIXELID_CAL_EN
    logic [7:0]  r_pixel_id;

    // Pixel address is latched at reset so later changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pixel_id <= pixelID;
        end else begin
            r_pixel_id <= r_pixel_id;
        end
    end

    assign w_cal = {2'b00, r_pixel_id};
`else
    assign w_cal = {r_s[30:26], r_s[4:0]};
`endif

    assign w_hit = (r_s[6:0] < occupancy) & ~dis;

    // Upper seed bits are non-zero, so the x^31+x^28+1 LFSR can never lock up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s  <= {23'h2AAAAA, pixelID};
            dout <= 30'd0;
        end else begin
            r_s  <= {r_s[29:0], r_s[30] ^ r_s[27]};
            dout <= w_hit ? {r_s[16:7], r_s[25:17], w_cal, 1'b1} : 30'd0;
        end
    end

endmodule

module tdc_test_pattern_gen #(
    parameter int         WORDWIDTH     = 15,
    parameter logic [8:0] PREDICT_STEPS = 9'd501
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_tdc_dis,
    input  logic        i_l1_dis,
    input  logic [7:0]  i_pixel_id,
    input  logic [6:0]  i_occupancy,
    output logic [29:0] o_dout,
    output logic        o_l1a,
    output logic        o_predict_l1a
);

    TDCTestPatternGen u_tdc (
        .clk       (clk),
        .reset     (reset),
        .dis       (i_tdc_dis),
        .pixelID   (i_pixel_id),
        .occupancy (i_occupancy),
        .dout      (o_dout)
    );

    TestL1Generator #(.WORDWIDTH(WORDWIDTH), .FORWARDSTEPS(9'd0)) u_l1 (
        .clk   (clk),
        .reset (reset),
        .dis   (i_l1_dis),
        .L1A   (o_l1a)
    );

    // Same sequence started PREDICT_STEPS ahead: announces each trigger early.
    TestL1Generator #(.WORDWIDTH(WORDWIDTH), .FORWARDSTEPS(PREDICT_STEPS)) u_l1_predict (
        .clk   (clk),
        .reset (reset),
        .dis   (i_l1_dis),
        .L1A   (o_predict_l1a)
    );

endmodule

// File: tb/tb_tdc_test_pattern_gen.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus hand-computed pins.
module tb_tdc_test_pattern_gen;

    localparam int P     = 32767;
    localparam int AHEAD = 501;

    logic        clk;
    logic        reset;
    logic        tdc_dis;
    logic        l1_dis;
    logic [7:0]  pixel;
    logic [6:0]  occ;
    logic [29:0] dout;
    logic        l1a;
    logic        pred;

    int checks = 0;
    int errors = 0;

    tdc_test_pattern_gen #(.WORDWIDTH(15), .PREDICT_STEPS(9'd501)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_tdc_dis     (tdc_dis),
        .i_l1_dis      (l1_dis),
        .i_pixel_id    (pixel),
        .i_occupancy   (occ),
        .o_dout        (dout),
        .o_l1a         (l1a),
        .o_predict_l1a (pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned seq [0:P-1];
    int unsigned m_s;
    int          m_idx;
    int unsigned m_pix;
    logic [29:0] e_dout;
    logic        e_l1;
    logic        e_pred;
    logic        started = 1'b0;

    initial begin
        int unsigned v;
        v = 32767;
        for (int j = 0; j < P; j++) begin
            seq[j] = v;
            v = ((v * 2) % 32768) + (((v / 16384) ^ (v / 8192)) % 2);
        end
    end

    function automatic int unsigned tdc_next(input int unsigned s);
        return ((s * 2) % 32'h8000_0000) + (((s / 32'h4000_0000) ^ (s / 32'h0800_0000)) % 2);
    endfunction

    function automatic logic [29:0] tdc_word(input int unsigned s, input logic d,
                                             input int unsigned o, input int unsigned pix);
        int unsigned toa, tot, cal;
        if (d || (s % 128) >= o) return 30'd0;
        toa = (s / 128) % 1024;
        tot = (s / 131072) % 512;
`ifdef TDC_PIXELID_CAL_EN
        cal = pix;
`else
        cal = ((s / 67108864) * 32) + (s % 32);
`endif
        return 30'(toa * 1048576 + tot * 2048 + cal * 2 + 1);
    endfunction

    function automatic logic l1_at(input int j);
        return (seq[j % P] % 32) == 0;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (!reset) begin
            m_s    <= 32'h2AAAAA00 + pixel;
            m_pix  <= pixel;
            m_idx  <= 0;
            e_dout <= 30'd0;
            e_l1   <= 1'b0;
            e_pred <= 1'b0;
        end else begin
            e_dout <= tdc_word(m_s, tdc_dis, occ, m_pix);
            e_l1   <= l1_at(m_idx) && !l1_dis;
            e_pred <= l1_at(m_idx + AHEAD) && !l1_dis;
            m_s    <= tdc_next(m_s);
            m_idx  <= (m_idx + 1) % P;
        end
    end

    task automatic chk(input string nm, input logic [29:0] act, input logic [29:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("dout_model", dout, e_dout);
            chk("l1a_model", {29'd0, l1a}, {29'd0, e_l1});
            chk("predict_model", {29'd0, pred}, {29'd0, e_pred});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int l1_cnt, pr_cnt, hits, bad;
        logic [29:0] first_word;
`ifdef TDC_PIXELID_CAL_EN
        first_word = {10'h154, 9'h155, 10'h005, 1'b1};
`else
        first_word = {10'h154, 9'h155, 10'h145, 1'b1};
`endif
        reset = 1'b0; tdc_dis = 1'b0; l1_dis = 1'b0; pixel = 8'h05; occ = 7'h06;
        repeat (3) begin
            @(negedge clk);
            chk("reset_dout", dout, 30'd0);
            chk("reset_l1a", {29'd0, l1a}, 30'd0);
        end
        reset = 1'b1;

        // One full L1 period from reset release.
        l1_cnt = 0; pr_cnt = 0; hits = 0; bad = 0;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            if (k == 1) chk("first_hit_word", dout, first_word);
            if (k == 5) chk("l1a_edge5_low", {29'd0, l1a}, 30'd0);
            if (k == 6) chk("l1a_edge6_high", {29'd0, l1a}, 30'd1);
            if (l1a) l1_cnt++;
            if (pred) pr_cnt++;
            if (dout[0]) hits++;
            if (!dout[0] && dout != 30'd0) bad++;
        end
        chk("l1a_period_count", 30'(l1_cnt), 30'd1023);
        chk("predict_period_count", 30'(pr_cnt), 30'd1023);
        chk("hit_rate_in_range", {29'd0, (hits >= 1382 && hits <= 1690)}, 30'd1);
        chk("no_partial_words", 30'(bad), 30'd0);

        occ = 7'd0; hits = 0;
        repeat (1000) begin @(negedge clk); if (dout != 30'd0) hits++; end
        chk("occ0_no_hits", 30'(hits), 30'd0);

        occ = 7'd127; tdc_dis = 1'b1; hits = 0;
        @(negedge clk);
        repeat (500) begin @(negedge clk); if (dout != 30'd0) hits++; end
        chk("dis_forces_zero", 30'(hits), 30'd0);

        tdc_dis = 1'b0; l1_dis = 1'b1; l1_cnt = 0;
        @(negedge clk);
        repeat (200) begin @(negedge clk); if (l1a || pred) l1_cnt++; end
        chk("l1_dis_forces_zero", 30'(l1_cnt), 30'd0);
        pixel = 8'hA3;
        repeat (200) @(negedge clk);
        l1_dis = 1'b0;
        repeat (2000) @(negedge clk);

        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_reset_dout", dout, 30'd0);
        reset = 1'b1; occ = 7'd64;
        repeat (3000) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
